seg_scan_capture: RTL and testbench

//  Receive-side counterpart of the 6-digit multiplexed 7-seg driver: samples seg_data/seg_cs
//  (looped back via spare IO or probed from a second board) and rebuilds the 24-bit hex/BCD word.

---
 rtl/seg_scan_capture.sv | 200 ++++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive side of a 6-digit multiplexed 7-segment display.
// Synchronizes and debounces the segment/select buses, decodes each stable digit to a
// nibble, and publishes one 24-bit frame per complete scan of all six digits.
// Optional feature: define SEGCAP_DP_EN to store decimal points and drive dp_out;
// otherwise dp_out is tied to zero.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          CS_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [7:0]  seg_data,
  input  logic [5:0]  seg_cs,
  output logic [23:0] bcd_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        scan_lost,
  output logic [5:0]  dp_out
);

  localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TimeW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYCLES);
  localparam logic [StabW-1:0] StabCap = StabW'(STABLE_CYCLES - 1);
  localparam logic [TimeW-1:0] TimeMax = TimeW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StWait, StCapt, StHold} state_e;

  logic [13:0]      sync1_q, sync2_q, prev_q;
  logic [13:0]      sample;
  logic [StabW-1:0] stab_cnt_q;
  logic             sample_chg;
  logic             cs_onehot;

  state_e           state_q;
  logic [5:0]       cap_cs_q;
  logic [7:0]       cap_seg_q;
  logic [23:0]      digits_q;
  logic [5:0]       mask_q;
  logic             err_acc_q;
  logic [TimeW-1:0] to_cnt_q;
  logic [23:0]      bcd_q;
  logic             fv_q, ferr_q, lost_q;

  logic [3:0]       nibble;
  logic             illegal;
  logic [23:0]      new_word;
  logic [5:0]       new_mask;

  // Polarity-normalized view of the synchronized buses: {cs[5:0], seg[7:0]}, active high.
  assign sample[7:0]  = SEG_ACTIVE_LOW ? ~sync2_q[7:0]  : sync2_q[7:0];
  assign sample[13:8] = CS_ACTIVE_LOW  ? ~sync2_q[13:8] : sync2_q[13:8];
  assign sample_chg   = (sample != prev_q);
  assign cs_onehot    = (sample[13:8] != 6'b0) &&
                        ((sample[13:8] & (sample[13:8] - 6'd1)) == 6'b0);

  // Two-stage synchronizer plus stability counter that saturates at STABLE_CYCLES.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      stab_cnt_q <= '0;
    end else begin
      sync1_q <= {seg_cs, seg_data};
      sync2_q <= sync1_q;
      prev_q  <= sample;
      if (sample_chg) begin
        stab_cnt_q <= '0;
      end else if (stab_cnt_q != StabMax) begin
        stab_cnt_q <= stab_cnt_q + 1'b1;
      end
    end
  end

  // Decode the captured pattern and build the candidate frame word and seen mask.
  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b0;
    case (cap_seg_q[6:0])
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: begin
        nibble  = 4'h0;
        illegal = 1'b1;
      end
    endcase
    new_word = digits_q;
    for (int k = 0; k < 6; k++) begin
      if (cap_cs_q[k]) new_word[4*k +: 4] = nibble;
    end
    new_mask = mask_q | cap_cs_q;
  end

`ifdef SEGCAP_DP_EN
  logic [5:0] dp_q, dp_out_q, new_dp;

  // Merge the captured decimal point into the per-digit dp store.
  always_comb begin
    new_dp = dp_q;
    for (int k = 0; k < 6; k++) begin
      if (cap_cs_q[k]) new_dp[k] = cap_seg_q[7];
    end
  end

  assign dp_out = dp_out_q;
`else
  logic unused_dp;
  assign unused_dp = cap_seg_q[7];
  assign dp_out    = 6'b0;
`endif

  // Capture FSM, digit store, frame publication and scan timeout.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q   <= StWait;
      cap_cs_q  <= '0;
      cap_seg_q <= '0;
      digits_q  <= '0;
      mask_q    <= '0;
      err_acc_q <= 1'b0;
      to_cnt_q  <= '0;
      bcd_q     <= '0;
      fv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      lost_q    <= 1'b0;
`ifdef SEGCAP_DP_EN
      dp_q      <= '0;
      dp_out_q  <= '0;
`endif
    end else begin
      fv_q <= 1'b0;
      unique case (state_q)
        StWait: begin
          // Latch the sample on entry so a change during CAPT cannot corrupt the digit.
          if (stab_cnt_q == StabCap && !sample_chg && cs_onehot) begin
            state_q   <= StCapt;
            cap_cs_q  <= sample[13:8];
            cap_seg_q <= sample[7:0];
          end
        end
        StCapt: state_q <= StHold;
        // A counter below max means the sample moved since the capture.
        StHold: if (sample_chg || stab_cnt_q != StabMax) state_q <= StWait;
        default: state_q <= StWait;
      endcase

      if (state_q == StCapt) begin
        digits_q <= new_word;
        to_cnt_q <= '0;
        lost_q   <= 1'b0;
`ifdef SEGCAP_DP_EN
        dp_q     <= new_dp;
`endif
        if (new_mask == 6'h3F) begin
          bcd_q     <= new_word;
          ferr_q    <= err_acc_q | illegal;
          fv_q      <= 1'b1;
          mask_q    <= '0;
          err_acc_q <= 1'b0;
`ifdef SEGCAP_DP_EN
          dp_out_q  <= new_dp;
`endif
        end else begin
          mask_q    <= new_mask;
          err_acc_q <= err_acc_q | illegal;
        end
      end else if (to_cnt_q == TimeMax) begin
        // Scan stalled: drop any partial frame but keep the last published one.
        lost_q    <= 1'b1;
        mask_q    <= '0;
        err_acc_q <= 1'b0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  assign bcd_data    = bcd_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign scan_lost   = lost_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture (active-low buses, shortened timeout).
module tb_seg_scan_capture;

  localparam int unsigned Timeout = 2000;
`ifdef SEGCAP_DP_EN
  localparam logic [5:0] DpExp = 6'b000100;
`else
  localparam logic [5:0] DpExp = 6'b000000;
`endif

  logic        clk_50mhz = 1'b0;
  logic        rst       = 1'b1;
  logic [7:0]  seg_data  = 8'hFF;
  logic [5:0]  seg_cs    = 6'h3F;
  logic [23:0] bcd_data;
  logic        frame_valid, frame_err, scan_lost;
  logic [5:0]  dp_out;

  seg_scan_capture #(
    .STABLE_CYCLES  (64),
    .TIMEOUT_CYCLES (Timeout),
    .SEG_ACTIVE_LOW (1'b1),
    .CS_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_50mhz   (clk_50mhz),
    .rst         (rst),
    .seg_data    (seg_data),
    .seg_cs      (seg_cs),
    .bcd_data    (bcd_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .scan_lost   (scan_lost),
    .dp_out      (dp_out)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Active-high segment patterns for hex digits 0..F.
  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int          n_checks = 0;
  int          n_pass   = 0;
  int          fv_cnt   = 0;
  int          base;
  logic [23:0] last_bcd = '0;
  logic        last_err = 1'b0;
  logic [5:0]  last_dp  = '0;

  // Record every published frame.
  always @(negedge clk_50mhz) begin
    if (frame_valid) begin
      fv_cnt++;
      last_bcd = bcd_data;
      last_err = frame_err;
      last_dp  = dp_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Show active-high pattern pat on digit k for n cycles, then a 10-cycle blank gap.
  task automatic show(input int k, input logic [7:0] pat, input int n);
    logic [5:0] one;
    one = 6'(1) << k;
    @(negedge clk_50mhz);
    seg_cs   = ~one;
    seg_data = ~pat;
    repeat (n - 1) @(negedge clk_50mhz);
    seg_cs   = 6'h3F;
    seg_data = 8'hFF;
    repeat (10) @(negedge clk_50mhz);
  endtask

  // Show digits first..last of word w, 100 cycles each.
  task automatic scan(input logic [23:0] w, input int first, input int last);
    for (int k = first; k <= last; k++) show(k, seg_tab[w[4*k +: 4]], 100);
  endtask

  initial begin
    // Reset state, including frame_valid during reset.
    repeat (5) @(negedge clk_50mhz);
    check("rst_bcd", 32'(bcd_data), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_err_lost", 32'({frame_err, scan_lost}), 32'h0);
    check("rst_dp", 32'(dp_out), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk_50mhz);

    // 1: plain scan of 1..6.
    base = fv_cnt;
    scan(24'h654321, 0, 5);
    check("t1_count", 32'(fv_cnt - base), 32'd1);
    check("t1_bcd", 32'(last_bcd), 32'h654321);
    check("t1_err", 32'(last_err), 32'h0);
    check("t1_dp", 32'(last_dp), 32'h0);
    check("t1_fv_idle", 32'(frame_valid), 32'h0);

    // 2: digit 0 too short; no frame until it is held long enough.
    base = fv_cnt;
    show(0, seg_tab[3], 30);
    scan(24'h654321, 1, 5);
    check("t2_short_none", 32'(fv_cnt - base), 32'd0);
    show(0, seg_tab[0], 100);
    check("t2_count", 32'(fv_cnt - base), 32'd1);
    check("t2_bcd", 32'(last_bcd), 32'h654320);

    // 3: illegal pattern 0x49 on digit 3.
    base = fv_cnt;
    scan(24'h654321, 0, 2);
    show(3, 8'h49, 100);
    scan(24'h654321, 4, 5);
    check("t3_count", 32'(fv_cnt - base), 32'd1);
    check("t3_bcd", 32'(last_bcd), 32'h650321);
    check("t3_err", 32'(last_err), 32'h1);

    // 6: dp lit on digit 2 only; error accumulator must be clear again.
    base = fv_cnt;
    scan(24'h654321, 0, 1);
    show(2, seg_tab[3] | 8'h80, 100);
    scan(24'h654321, 3, 5);
    check("t6_count", 32'(fv_cnt - base), 32'd1);
    check("t6_bcd", 32'(last_bcd), 32'h654321);
    check("t6_err", 32'(last_err), 32'h0);
    check("t6_dp", 32'(last_dp), 32'(DpExp));

    // 5: reset after four digits discards them.
    base = fv_cnt;
    scan(24'h654321, 0, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk_50mhz);
    check("t5_rst_bcd", 32'(bcd_data), 32'h0);
    check("t5_rst_flags", 32'({frame_valid, frame_err, scan_lost, dp_out}), 32'h0);
    rst = 1'b0;
    scan(24'h654321, 4, 5);
    check("t5_partial_none", 32'(fv_cnt - base), 32'd0);
    scan(24'h654321, 0, 5);
    check("t5_count", 32'(fv_cnt - base), 32'd1);
    check("t5_bcd", 32'(last_bcd), 32'h654321);

    // 4: stalled scan times out and drops the partial frame.
    base = fv_cnt;
    scan(24'hCBA987, 3, 5);
    repeat (Timeout + 100) @(negedge clk_50mhz);
    check("t4_lost", 32'(scan_lost), 32'h1);
    check("t4_stall_none", 32'(fv_cnt - base), 32'd0);
    check("t4_bcd_kept", 32'(bcd_data), 32'h654321);
    scan(24'hCBA987, 0, 2);
    check("t4_relock", 32'(scan_lost), 32'h0);
    check("t4_mask_cleared", 32'(fv_cnt - base), 32'd0);
    scan(24'hCBA987, 3, 5);
    check("t4_count", 32'(fv_cnt - base), 32'd1);
    check("t4_bcd", 32'(last_bcd), 32'hCBA987);
    check("t4_err", 32'(last_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
